// File: rtl/cordic_rotation_core.sv
// Iterative rotation-mode CORDIC engine.
// Each clock performs one shift-add micro-rotation. The arctan angle for the
// current step comes from an external LUT that is indexed by count. The CORDIC
// gain (K ~= 1.6468) is not compensated, so x/y carry two guard bits.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start; count held at 0
// ROTATE | one micro-rotation per clock, count = iteration index
// DONE   | one-cycle done pulse; start here chains the next operation
module cordic_rotation_core #(
    parameter int WIDTH = 16,
    parameter int ITER  = 7
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic signed [WIDTH-1:0] x_in,
    input  logic signed [WIDTH-1:0] y_in,
    input  logic signed [7:0]       angle_in,
    input  logic        [7:0]       lut_angle,
    output logic        [2:0]       count,
    output logic                    busy,
    output logic                    done,
    output logic signed [WIDTH+1:0] x_out,
    output logic signed [WIDTH+1:0] y_out,
    output logic signed [8:0]       z_out
);

    localparam int         XW        = WIDTH + 2;
    localparam logic [2:0] ITER_LAST = 3'(ITER - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ROTATE,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic signed [XW-1:0] x_r, y_r;
    logic signed [8:0]    z_r;
    logic signed [XW-1:0] x_sh, y_sh, x_nxt, y_nxt;
    logic signed [8:0]    z_nxt, lut_ext;
    logic                 last_iter;
    logic                 accept;

    assign last_iter = (count == ITER_LAST);
    assign accept    = start && (state != S_ROTATE);
    assign busy      = (state == S_ROTATE);
    assign done      = (state == S_DONE);

    // One micro-rotation; the direction follows the sign of the residual angle.
    always_comb begin
        x_sh    = x_r >>> count;
        y_sh    = y_r >>> count;
        lut_ext = {1'b0, lut_angle};
        if (!z_r[8]) begin
            x_nxt = x_r - y_sh;
            y_nxt = y_r + x_sh;
            z_nxt = z_r - lut_ext;
        end else begin
            x_nxt = x_r + y_sh;
            y_nxt = y_r - x_sh;
            z_nxt = z_r + lut_ext;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_ROTATE;
            S_ROTATE: if (last_iter) state_nxt = S_DONE;
            S_DONE:   state_nxt = start ? S_ROTATE : S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // State register, operand capture, iteration datapath and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            count <= '0;
            x_r   <= '0;
            y_r   <= '0;
            z_r   <= '0;
            x_out <= '0;
            y_out <= '0;
            z_out <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                x_r   <= XW'(x_in);
                y_r   <= XW'(y_in);
                z_r   <= 9'(angle_in);
                count <= '0;
            end else if (state == S_ROTATE) begin
                x_r <= x_nxt;
                y_r <= y_nxt;
                z_r <= z_nxt;
                if (last_iter) begin
                    x_out <= x_nxt;
                    y_out <= y_nxt;
                    z_out <= z_nxt;
                    count <= '0;
                end else begin
                    count <= count + 3'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_cordic_rotation_core.sv
// Scoreboard testbench for cordic_rotation_core with a behavioural CORDIC model.
module tb_cordic_rotation_core;

    localparam int WIDTH = 16;
    localparam int ITER  = 7;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    start = 1'b0;
    logic signed [WIDTH-1:0] x_in = '0;
    logic signed [WIDTH-1:0] y_in = '0;
    logic signed [7:0]       angle_in = '0;
    logic        [7:0]       lut_angle;
    logic        [2:0]       count;
    logic                    busy;
    logic                    done;
    logic signed [WIDTH+1:0] x_out;
    logic signed [WIDTH+1:0] y_out;
    logic signed [8:0]       z_out;

    cordic_rotation_core #(.WIDTH(WIDTH), .ITER(ITER)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .x_in      (x_in),
        .y_in      (y_in),
        .angle_in  (angle_in),
        .lut_angle (lut_angle),
        .count     (count),
        .busy      (busy),
        .done      (done),
        .x_out     (x_out),
        .y_out     (y_out),
        .z_out     (z_out)
    );

    always #5 clk = ~clk;

    // arctan(2^-i) in units of 45deg/100, truncated; index 7 reads 0.
    int lut [8] = '{100, 59, 31, 15, 7, 3, 1, 0};
    assign lut_angle = 8'(lut[count]);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int x;
        int y;
        int z;
        int done_cyc;
    } exp_t;
    exp_t q[$];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int floor_shift(input int v, input int s);
        int p;
        int r;
        p = 1 << s;
        r = v / p;
        if (v < 0 && r * p != v) r = r - 1;
        return r;
    endfunction

    // Behavioural rotation: greedy drive of the residual angle toward zero.
    function automatic void cordic_ref(input int xi, input int yi, input int ai,
                                       output int xo, output int yo, output int zo);
        int x, y, z, xs, ys;
        x = xi; y = yi; z = ai;
        for (int i = 0; i < ITER; i++) begin
            xs = floor_shift(x, i);
            ys = floor_shift(y, i);
            if (z >= 0) begin
                x = x - ys; y = y + xs; z = z - lut[i];
            end else begin
                x = x + ys; y = y - xs; z = z + lut[i];
            end
        end
        xo = x; yo = y; zo = z;
    endfunction

    task automatic push_exp(input int xi, input int yi, input int ai, input int dcyc);
        exp_t e;
        cordic_ref(xi, yi, ai, e.x, e.y, e.z);
        e.done_cyc = dcyc;
        q.push_back(e);
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic set_ops(input int xi, input int yi, input int ai);
        x_in     = WIDTH'(xi);
        y_in     = WIDTH'(yi);
        angle_in = 8'(ai);
    endtask

    // One-cycle start pulse; the expected result is pushed when the start is issued.
    task automatic issue(input int xi, input int yi, input int ai);
        set_ops(xi, yi, ai);
        start = 1'b1;
        push_exp(xi, yi, ai, cyc + 1 + ITER);
        step();
        start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 200 && q.size() > 0; n++) step();
        if (q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL timeout: %0d results still pending, want 0", q.size());
            q.delete();
        end
    endtask

    // Monitor: checks handshake timing, LUT index and results against the scoreboard.
    always @(negedge clk) begin
        bit exp_busy;
        if (!rst) begin
            exp_busy = (q.size() > 0) && (cyc >= q[0].done_cyc - ITER) && (cyc < q[0].done_cyc);
            chk("busy", longint'(busy), longint'(exp_busy));
            if (busy && q.size() > 0)
                chk("count", longint'(count), longint'(cyc - (q[0].done_cyc - ITER)));
            else if (!busy)
                chk("count_idle", longint'(count), 0);
            if (done) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    chk("done_cycle", cyc, q[0].done_cyc);
                    chk("x_out", longint'($signed(x_out)), q[0].x);
                    chk("y_out", longint'($signed(y_out)), q[0].y);
                    chk("z_out", longint'($signed(z_out)), q[0].z);
                    void'(q.pop_front());
                end
            end else if (q.size() > 0 && cyc >= q[0].done_cyc) begin
                chk("missing_done", 0, 1);
                void'(q.pop_front());
            end
        end
    end

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"},  longint'(busy), 0);
        chk({tag, "_done"},  longint'(done), 0);
        chk({tag, "_count"}, longint'(count), 0);
        chk({tag, "_x_out"}, longint'($signed(x_out)), 0);
        chk({tag, "_y_out"}, longint'($signed(y_out)), 0);
        chk({tag, "_z_out"}, longint'($signed(z_out)), 0);
    endtask

    initial begin
        int k;
        #1;
        chk_zero("reset");
        repeat (3) step();
        rst = 1'b0;
        step();

        // Directed rotations: 0, +45 and -45 degrees.
        issue(1000, 0, 0);     wait_idle();
        issue(1000, 0, 100);   wait_idle();
        issue(1000, 0, -100);  wait_idle();
        issue(-20000, 15000, -128); wait_idle();
        issue(32767, -32767, 127);  wait_idle();

        // start held high: A then B back to back, done every ITER+1 cycles.
        set_ops(1234, -567, 37);
        start = 1'b1;
        push_exp(1234, -567, 37, cyc + 1 + ITER);
        step();
        k = cyc;
        set_ops(-800, 2500, -90);
        push_exp(-800, 2500, -90, k + 2 * ITER + 1);
        repeat (ITER + 1) step();
        start = 1'b0;
        wait_idle();

        // start pulsed during ROTATE is ignored.
        issue(3000, 1000, 60);
        step(); step();
        set_ops(-5000, -5000, -50);
        start = 1'b1;
        step();
        start = 1'b0;
        wait_idle();

        // Asynchronous reset mid-ROTATE abandons the operation.
        issue(7000, -3000, 80);
        step(); step();
        #2;
        rst = 1'b1;
        q.delete();
        #1;
        chk_zero("midrst");
        step();
        rst = 1'b0;
        step();
        issue(1000, 0, 100);
        wait_idle();

        // Randomized operations, including chained starts from DONE.
        for (int n = 0; n < 40; n++) begin
            int xr, yr, ar, gap;
            xr  = int'($urandom_range(0, 65534)) - 32767;
            yr  = int'($urandom_range(0, 65534)) - 32767;
            ar  = int'($urandom_range(0, 255)) - 128;
            gap = int'($urandom_range(0, 2));
            issue(xr, yr, ar);
            wait_idle();
            repeat (gap) step();
        end

        repeat (3) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
